fft_sample_deserializer: RTL
============================

// Module: fft_sample_deserializer
// PURPOSE
//   Front-end stage feeding FFT_StageVRTL stage 0. Collects a serial stream of real fixed-point
//   samples, one per val/rdy handshake, into an N_SAMPLES-wide parallel frame.
//   Presents the frame as send_msg_real/send_msg_imag with a single frame-level send_val/send_rdy.
//   Imaginary lanes are zero. Sample order is natural: sample k goes to lane k.
//   The crossbar inside the stage performs all reordering.
// PARAMETERS
//   BIT_WIDTH   32  sample width, two's-complement fixed point
//   DECIMAL_PT  16  fractional bits; carried for interface parity; no arithmetic is done here
//   N_SAMPLES   8   frame length; power of two, >= 2
// PORTS
//   clk            in   1                     clock
//   reset          in   1                     synchronous, active-high
//   recv_msg       in   BIT_WIDTH             serial input sample
//   recv_val       in   1                     input sample valid
//   recv_rdy       out  1                     deserializer can accept a sample
//   send_msg_real  out  BIT_WIDTH x N_SAMPLES frame real lanes, [N_SAMPLES-1:0]
//   send_msg_imag  out  BIT_WIDTH x N_SAMPLES frame imag lanes, [N_SAMPLES-1:0], always 0
//   send_val       out  1                     a complete frame is held
//   send_rdy       in   1                     downstream stage accepts the frame
// BEHAVIOUR
//   Clocking and reset
//   - One clock, clk. Reset is synchronous and active-high on reset.
//   - Reset values: state=FILL, count=0, every send_msg_real lane=0, send_val=0.
//   - recv_rdy evaluates to 1 on the first cycle after reset.
//   - Reset mid-frame discards the partial frame. Reset while FULL discards the pending frame.
//   Handshakes
//   - A transfer occurs on a rising edge where val && rdy. There are no other transfers.
//   - recv_rdy = (state==FILL) || (state==FULL && send_rdy). This is combinational.
//   - send_val = (state==FULL). It is registered, with no combinational path from recv_*.
//   - send_msg_real is stable for the whole time send_val=1. Lanes change only on a recv transfer.
//   State machine (2 states; count is $clog2(N_SAMPLES) bits)
//   - FILL, recv transfer, count<N_SAMPLES-1:
//     lane[count] <= recv_msg; count++.
//   - FILL, recv transfer, count==N_SAMPLES-1:
//     write the last lane; count <= 0; state -> FULL.
//   - FULL, send transfer, no recv transfer:
//     state -> FILL; count stays 0.
//   - FULL, send transfer and recv transfer in the same edge:
//     lane[0] <= recv_msg; count <= 1; state -> FILL. This gives zero bubble.
//   - FULL, send_rdy=0:
//     hold; recv_rdy=0; an input offered while recv_val=1 is stalled, not dropped.
//   Latency and throughput
//   - send_val rises on the edge that captures sample N_SAMPLES-1, so it is visible the next cycle.
//   - Sustained throughput is 1 sample per cycle when send_rdy is held at 1.
//   Width rules
//   - recv_msg is stored verbatim. There is no rounding, shifting or saturation.
//   - send_msg_imag is tied to BIT_WIDTH'b0.
//   - Old lane contents are stale during FILL. They are not cleared, and they are invisible
//     because send_val=0.
// STRUCTURE
//   - Shared package fft_pkg: deser_state_t enum {FILL, FULL}.
//   - Also in fft_pkg: a CLOG2_N helper used for count width.
//   - No sub-module. One always_ff holds state, count and lanes. One always_comb computes
//     next-state and recv_rdy.
//   - Lane writes use a decoded one-hot write enable from count.
// TESTING (N_SAMPLES=8, BIT_WIDTH=32, DECIMAL_PT=16 unless stated)
//   1. Fill: reset, then feed 8 samples 0x00010000..0x00080000 with send_rdy=0.
//      -> send_val=1 the cycle after the 8th.
//      -> lane k = (k+1)<<16; all imag lanes = 0; recv_rdy=0.
//   2. Back-pressure: continue case 1, hold send_rdy=0 for 5 cycles with recv_val=1.
//      -> frame unchanged; no sample consumed.
//      -> raise send_rdy: the frame is accepted and the offered sample lands in lane 0; count=1.
//   3. Streaming: send_rdy=1 and recv_val=1 constantly for 24 samples.
//      -> exactly 3 frames, send_val pulses every 8 cycles, no sample lost or duplicated.
//   4. Gaps: random recv_val (50%) and random send_rdy.
//      -> output frames equal input order chunked by 8, checked against a scoreboard.
//   5. Reset mid-fill: assert reset after 3 samples.
//      -> send_val=0; the next 8 samples form a frame with no residue of the first 3.
//   6. Negative/extreme values: feed 0x80000000 and 0xFFFFFFFF.
//      -> the values appear bit-exact in the lanes.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT front-end types: deserializer state encoding and the counter-width helper.
package fft_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } deser_state_t;

  // Bits needed to index n lanes (minimum 1 so a 2-lane frame still gets a counter bit).
  function automatic int CLOG2_N(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fft_sample_deserializer.sv
// Serial-to-parallel front end for FFT stage 0: packs N_SAMPLES real samples, in arrival
// order, into one frame and offers it with a single frame-level val/rdy handshake.
module fft_sample_deserializer
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BIT_WIDTH-1:0]                recv_msg,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_imag,
  output logic                                send_val,
  input  logic                                send_rdy
);

  localparam int                CW       = CLOG2_N(N_SAMPLES);
  localparam logic [CW-1:0]     CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(N_SAMPLES - 1);
  localparam logic [N_SAMPLES-1:0] LANE_ONE = N_SAMPLES'(1);
  localparam logic [31:0]       DEC_PT_W = 32'(DECIMAL_PT);

  deser_state_t                        state_q, state_d;
  logic [CW-1:0]                       count_q, count_d;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] lanes_q;
  logic                                send_val_q;
  logic [N_SAMPLES-1:0]                lane_we_s;
  logic                                dec_pt_unused_s;

  // The fixed-point position only matters downstream; no arithmetic happens here.
  assign dec_pt_unused_s = ^DEC_PT_W;

  // Next-state, count and one-hot lane write enable; recv_rdy sees send_rdy directly in FULL.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lane_we_s = '0;
    recv_rdy  = 1'b0;
    case (state_q)
      FILL: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          lane_we_s = LANE_ONE << count_q;
          if (count_q == CNT_LAST) begin
            count_d = CNT_ZERO;
            state_d = FULL;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end else begin
          count_d = count_q;
        end
      end
      FULL: begin
        recv_rdy = send_rdy;
        if (send_rdy) begin
          state_d = FILL;
          if (recv_val) begin
            // Frame leaves and the next one starts on the same edge: no bubble.
            lane_we_s = LANE_ONE;
            count_d   = CNT_ONE;
          end else begin
            count_d = CNT_ZERO;
          end
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = FILL;
        count_d = CNT_ZERO;
      end
    endcase
  end

  // State, count, lane storage and the registered frame-valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      count_q    <= CNT_ZERO;
      lanes_q    <= '0;
      send_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      send_val_q <= (state_d == FULL);
      for (int k = 0; k < N_SAMPLES; k++) begin
        if (lane_we_s[k]) begin
          lanes_q[k] <= recv_msg;
        end
      end
    end
  end

  assign send_val      = send_val_q;
  assign send_msg_real = lanes_q;
  assign send_msg_imag = '0;

endmodule
